// File: rtl/ysyx_22040931_iter_divider_if.sv
// Divide request/response bundle between the EX-stage ALU (master) and the iterative divider (slave).
interface ysyx_22040931_iter_divider_if #(
    parameter int XLEN = 64
);
    logic            id_valid;
    logic            ex_ready;
    logic            div_ena;
    logic            w;
    logic            div_signed;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            div_ready;
    logic            div_valid;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;

    modport master (
        output id_valid, ex_ready, div_ena, w, div_signed, dividend, divisor,
        input  div_ready, div_valid, quotient, remainder
    );

    modport slave (
        input  id_valid, ex_ready, div_ena, w, div_signed, dividend, divisor,
        output div_ready, div_valid, quotient, remainder
    );
endinterface

// File: rtl/ysyx_22040931_iter_divider.sv
// Radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W forms; one quotient bit per cycle,
// with divide-by-zero and signed overflow resolved at accept without iterating.
module ysyx_22040931_iter_divider #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input logic                          clock,
    input logic                          reset,
    ysyx_22040931_iter_divider_if.slave  bus
);
    localparam int HALF = XLEN / 2;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  a_q, a_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [XLEN-1:0]  r_q, r_d;
    logic [XLEN-1:0]  q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             is_w_q, is_w_d;
    logic [XLEN-1:0]  quotient_q, quotient_d;
    logic [XLEN-1:0]  remainder_q, remainder_d;

    logic             div_ready, div_valid;
    logic             accept, last_iter;
    logic [XLEN-1:0]  op_a, op_b, abs_a, abs_b, min_val, zero_rem;
    logic             sign_a, sign_b, div_zero, overflow;
    logic [XLEN:0]    rem_shift, rem_diff;
    logic             q_bit;
    logic [XLEN-1:0]  r_step, q_step, q_signed, r_signed, q_final, r_final;

    // Operand conditioning: W forms work on the low half, extended as the signedness dictates.
    always_comb begin
        if (bus.w) begin
            op_a = bus.div_signed ? {{HALF{bus.dividend[HALF-1]}}, bus.dividend[HALF-1:0]}
                                  : {{HALF{1'b0}}, bus.dividend[HALF-1:0]};
            op_b = bus.div_signed ? {{HALF{bus.divisor[HALF-1]}}, bus.divisor[HALF-1:0]}
                                  : {{HALF{1'b0}}, bus.divisor[HALF-1:0]};
            min_val  = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
            zero_rem = {{HALF{bus.dividend[HALF-1]}}, bus.dividend[HALF-1:0]};
        end else begin
            op_a     = bus.dividend;
            op_b     = bus.divisor;
            min_val  = {1'b1, {(XLEN-1){1'b0}}};
            zero_rem = bus.dividend;
        end
        sign_a   = bus.div_signed & op_a[XLEN-1];
        sign_b   = bus.div_signed & op_b[XLEN-1];
        abs_a    = sign_a ? -op_a : op_a;
        abs_b    = sign_b ? -op_b : op_b;
        div_zero = (op_b == '0);
        overflow = bus.div_signed & (op_a == min_val) & (&op_b);
    end

    assign accept    = (state_q == IDLE) & bus.id_valid & bus.div_ena;
    assign last_iter = (cnt_q == CNT_W'(1));

    // One restoring step; the 65-bit shift keeps unsigned divisors near 2^64 exact.
    always_comb begin
        rem_shift = {r_q, a_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, b_q};
        q_bit     = ~rem_diff[XLEN];
        r_step    = q_bit ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
        q_step    = {q_q[XLEN-2:0], q_bit};
        q_signed  = neg_quo_q ? -q_step : q_step;
        r_signed  = neg_rem_q ? -r_step : r_step;
        q_final   = is_w_q ? {{HALF{q_signed[HALF-1]}}, q_signed[HALF-1:0]} : q_signed;
        r_final   = is_w_q ? {{HALF{r_signed[HALF-1]}}, r_signed[HALF-1:0]} : r_signed;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (div_zero | overflow) ? DONE : CALC;
            CALC:    if (last_iter) state_d = DONE;
            DONE:    if (bus.ex_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        div_ready = (state_q == IDLE);
        div_valid = (state_q == DONE);
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        r_d         = r_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        is_w_d      = is_w_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // W dividends are pre-aligned to the top so iteration always starts at the MSB.
                    a_d       = bus.w ? {abs_a[HALF-1:0], {HALF{1'b0}}} : abs_a;
                    b_d       = abs_b;
                    r_d       = '0;
                    q_d       = '0;
                    cnt_d     = bus.w ? CNT_W'(HALF) : CNT_W'(XLEN);
                    neg_quo_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    is_w_d    = bus.w;
                    if (div_zero) begin
                        quotient_d  = '1;
                        remainder_d = zero_rem;
                    end else if (overflow) begin
                        quotient_d  = min_val;
                        remainder_d = '0;
                    end
                end
            end
            CALC: begin
                a_d   = {a_q[XLEN-2:0], 1'b0};
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (last_iter) begin
                    quotient_d  = q_final;
                    remainder_d = r_final;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            is_w_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            is_w_q      <= is_w_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign bus.div_ready = div_ready;
    assign bus.div_valid = div_valid;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
endmodule

// File: tb/tb_ysyx_22040931_iter_divider.sv
// Directed and randomized checks of the iterative divider with an expected-result scoreboard.
module tb_ysyx_22040931_iter_divider;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ysyx_22040931_iter_divider_if #(.XLEN(64)) bus();
    ysyx_22040931_iter_divider #(.XLEN(64), .CNT_W(7)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [63:0] q;
        logic [63:0] r;
        logic [31:0] lat;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] last_q = '0;
    logic [63:0] last_r = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Reference built on the language's own truncating division plus the RISC-V corner rules.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic w, input logic s);
        exp_t e;
        logic signed [31:0] sa32, sb32;
        logic signed [63:0] sa, sb;
        logic [31:0] q32, r32;
        e.lat = w ? 32'd33 : 32'd65;
        if (w) begin
            if (b[31:0] == 32'd0) begin
                e.q = '1; e.r = {{32{a[31]}}, a[31:0]}; e.lat = 32'd1;
            end else if (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
                e.q = 64'hFFFF_FFFF_8000_0000; e.r = '0; e.lat = 32'd1;
            end else begin
                if (s) begin
                    sa32 = a[31:0]; sb32 = b[31:0];
                    q32 = sa32 / sb32; r32 = sa32 % sb32;
                end else begin
                    q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
                end
                e.q = {{32{q32[31]}}, q32};
                e.r = {{32{r32[31]}}, r32};
            end
        end else begin
            if (b == 64'd0) begin
                e.q = '1; e.r = a; e.lat = 32'd1;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                e.q = 64'h8000_0000_0000_0000; e.r = '0; e.lat = 32'd1;
            end else if (s) begin
                sa = a; sb = b;
                e.q = sa / sb; e.r = sa % sb;
            end else begin
                e.q = a / b; e.r = a % b;
            end
        end
        return e;
    endfunction

    task automatic issue_exp(input logic [63:0] a, input logic [63:0] b, input logic w_in,
                             input logic s_in, input logic [63:0] q, input logic [63:0] r,
                             input int lat);
        exp_t e;
        int t = 0;
        while (bus.div_ready !== 1'b1 && t < 200) begin
            @(posedge clock); #1; t++;
        end
        check("ready_before_issue", 64'(bus.div_ready), 64'd1);
        bus.id_valid   = 1'b1;
        bus.div_ena    = 1'b1;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.w          = w_in;
        bus.div_signed = s_in;
        e.q = q; e.r = r; e.lat = 32'(lat);
        sb.push_back(e);
        @(posedge clock); #1;
        bus.id_valid   = 1'b0;
        bus.div_ena    = 1'b0;
        bus.dividend   = {$urandom, $urandom};
        bus.divisor    = {$urandom, $urandom};
        bus.w          = 1'($urandom);
        bus.div_signed = 1'($urandom);
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic w_in, input logic s_in);
        exp_t e;
        e = model(a, b, w_in, s_in);
        issue_exp(a, b, w_in, s_in, e.q, e.r, int'(e.lat));
    endtask

    // Called in cycle 1 after accept; waits for the result, applies backpressure, then retires it.
    task automatic run_op(input string tag, input int hold);
        exp_t e;
        int   cyc = 1;
        bit   rdy_seen = 1'b0;
        while (bus.div_valid !== 1'b1 && cyc < 200) begin
            if (bus.div_ready !== 1'b0) rdy_seen = 1'b1;
            @(posedge clock); #1; cyc++;
        end
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_valid"}, 64'(bus.div_valid), 64'd1);
        check({tag, "_latency"}, 64'(cyc), 64'(e.lat));
        check({tag, "_ready_low_busy"}, 64'(rdy_seen), 64'd0);
        check({tag, "_ready_in_done"}, 64'(bus.div_ready), 64'd0);
        check({tag, "_quotient"}, bus.quotient, e.q);
        check({tag, "_remainder"}, bus.remainder, e.r);
        $display("op %s: quotient=0x%h remainder=0x%h latency=%0d", tag, bus.quotient, bus.remainder, cyc);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check({tag, "_bp_valid"}, 64'(bus.div_valid), 64'd1);
            check({tag, "_bp_quotient"}, bus.quotient, e.q);
            check({tag, "_bp_remainder"}, bus.remainder, e.r);
        end
        bus.ex_ready = 1'b1;
        @(posedge clock); #1;
        bus.ex_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(bus.div_valid), 64'd0);
        check({tag, "_ready_back"}, 64'(bus.div_ready), 64'd1);
        check({tag, "_hold_quotient"}, bus.quotient, e.q);
        check({tag, "_hold_remainder"}, bus.remainder, e.r);
        last_q = e.q;
        last_r = e.r;
    endtask

    initial begin
        logic [63:0] ra, rb;
        int          vcnt;
        reset          = 1'b0;
        bus.id_valid   = 1'b0;
        bus.ex_ready   = 1'b0;
        bus.div_ena    = 1'b0;
        bus.w          = 1'b0;
        bus.div_signed = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", 64'(bus.div_ready), 64'd1);
        check("rst_valid", 64'(bus.div_valid), 64'd0);
        check("rst_quotient", bus.quotient, 64'd0);
        check("rst_remainder", bus.remainder, 64'd0);
        reset = 1'b1;
        @(posedge clock); #1;

        issue_exp(64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65);
        run_op("divu_100_7", 0);

        issue_exp(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b1,
                  64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("div_m7_2_bp", 5);

        issue_exp(64'h1234, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1);
        run_op("divu_by_zero", 0);

        issue_exp(64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
                  64'hFFFF_FFFF_8000_0000, 64'd0, 1);
        run_op("divw_overflow", 0);

        issue_exp(64'h0000_0000_FFFF_FFFF, 64'h10, 1'b1, 1'b0,
                  64'h0000_0000_0FFF_FFFF, 64'hF, 33);
        run_op("divuw_ffffffff_16", 0);

        issue_exp(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
                  64'h8000_0000_0000_0000, 64'd0, 1);
        run_op("div_overflow64", 0);

        issue_exp(64'hDEAD_0000_FFFF_FFFF, 64'd1, 1'b1, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33);
        run_op("divuw_sext_result", 0);

        issue_exp(64'h0000_0001_8000_0001, 64'hABCD_0000_0000_0000, 1'b1, 1'b1,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1);
        run_op("remw_by_zero", 0);

        issue_exp(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0003, 1'b0, 1'b0,
                  64'h5555_5555_5555_5555, 64'd0, 65);
        run_op("divu_max_3", 0);

        for (int i = 0; i < 6; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} >> $urandom_range(0, 60);
            issue(ra, rb, i[0], i[1]);
            run_op($sformatf("rand%0d", i), 0);
        end

        // A request with div_ena low must be ignored.
        bus.id_valid = 1'b1;
        bus.div_ena  = 1'b0;
        bus.dividend = 64'd55;
        bus.divisor  = 64'd5;
        repeat (3) @(posedge clock);
        #1;
        check("noop_ready", 64'(bus.div_ready), 64'd1);
        check("noop_valid", 64'(bus.div_valid), 64'd0);
        check("noop_quotient", bus.quotient, last_q);
        check("noop_remainder", bus.remainder, last_r);
        bus.id_valid = 1'b0;
        $display("op noop: quotient=0x%h remainder=0x%h", bus.quotient, bus.remainder);

        // Reset during CALC cycle 10 aborts the operation.
        issue_exp(64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 65);
        void'(sb.pop_back());
        repeat (9) @(posedge clock);
        #1;
        check("calc_busy", 64'(bus.div_ready), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        check("abort_ready", 64'(bus.div_ready), 64'd1);
        check("abort_valid", 64'(bus.div_valid), 64'd0);
        check("abort_quotient", bus.quotient, 64'd0);
        check("abort_remainder", bus.remainder, 64'd0);
        vcnt = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clock); #1;
            if (bus.div_valid !== 1'b0) vcnt++;
        end
        check("abort_no_result", 64'(vcnt), 64'd0);
        $display("op abort: ready=%0b valid=%0b", bus.div_ready, bus.div_valid);

        issue_exp(64'd1000, 64'd9, 1'b0, 1'b0, 64'd111, 64'd1, 65);
        run_op("after_abort", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
